// File: rtl/sc_move_arbiter.sv
// sc_move_arbiter: merges synchronised player buttons and lane-shift ticks into one acknowledged command stream.
// Optional held-direction auto-repeat is built when SC_MOVEARBITER_REPEAT_EN is defined.
module sc_move_arbiter #(
    parameter int unsigned GAP_CYCLES    = 12500000,
    parameter int unsigned REPEAT_CYCLES = 12500000
) (
    input  logic       SC_MOVEARBITER_CLOCK_50,
    input  logic       SC_MOVEARBITER_RESET_InLow,
    input  logic       SC_MOVEARBITER_startButton_InLow,
    input  logic       SC_MOVEARBITER_upButton_InLow,
    input  logic       SC_MOVEARBITER_downButton_InLow,
    input  logic       SC_MOVEARBITER_leftButton_InLow,
    input  logic       SC_MOVEARBITER_rightButton_InLow,
    input  logic       SC_MOVEARBITER_bottomsidecomparator_InLow,
    input  logic       SC_MOVEARBITER_laneTick_InHigh,
    input  logic       SC_MOVEARBITER_cmdAck_InHigh,
    output logic       SC_MOVEARBITER_cmdValid_OutHigh,
    output logic [2:0] SC_MOVEARBITER_cmd_Out,
    output logic       SC_MOVEARBITER_busy_OutHigh,
    output logic       SC_MOVEARBITER_overrun_OutHigh
);

    localparam int unsigned MAXC = (GAP_CYCLES > REPEAT_CYCLES) ? GAP_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_START = 3'd1,
        CMD_UP    = 3'd2,
        CMD_DOWN  = 3'd3,
        CMD_LEFT  = 3'd4,
        CMD_RIGHT = 3'd5,
        CMD_SHIFT = 3'd6
    } cmd_t;

    state_t      r_state, w_state_nxt;
    cmd_t        r_cmd, w_cmd_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic [4:0]  w_btn_raw;
    logic [4:0]  r_btn_s1, r_btn_s2;
    logic [4:0]  w_pressed;
    logic [1:0]  r_sync_vld;
    logic        r_armed, w_armed_eff, w_arm_clr;
    logic        r_tick_pend, r_overrun;
    logic        w_shift_ack;
    logic [4:0]  w_dir_latch;
    logic        w_rpt_fire;

    // bit order: {right, left, down, up, start}
    assign w_btn_raw = {SC_MOVEARBITER_rightButton_InLow, SC_MOVEARBITER_leftButton_InLow,
                        SC_MOVEARBITER_downButton_InLow, SC_MOVEARBITER_upButton_InLow,
                        SC_MOVEARBITER_startButton_InLow};
    assign w_pressed = ~r_btn_s2;

    always_ff @(posedge SC_MOVEARBITER_CLOCK_50 or negedge SC_MOVEARBITER_RESET_InLow) begin
        if (!SC_MOVEARBITER_RESET_InLow) begin
            r_btn_s1   <= '1;
            r_btn_s2   <= '1;
            r_sync_vld <= '0;
        end else begin
            r_btn_s1   <= w_btn_raw;
            r_btn_s2   <= r_btn_s1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
        end
    end

    // Synchroniser reset values must not count as a release, hence the r_sync_vld qualifier.
    always_ff @(posedge SC_MOVEARBITER_CLOCK_50 or negedge SC_MOVEARBITER_RESET_InLow) begin
        if (!SC_MOVEARBITER_RESET_InLow) begin
            r_armed <= 1'b0;
        end else if (w_arm_clr) begin
            r_armed <= 1'b0;
        end else if ((&r_btn_s2 && r_sync_vld[1]) || w_rpt_fire) begin
            r_armed <= 1'b1;
        end
    end

    assign w_armed_eff = r_armed | w_rpt_fire;
    assign w_shift_ack = (r_state == S_ISSUE) && SC_MOVEARBITER_cmdAck_InHigh && (r_cmd == CMD_SHIFT);

    always_ff @(posedge SC_MOVEARBITER_CLOCK_50 or negedge SC_MOVEARBITER_RESET_InLow) begin
        if (!SC_MOVEARBITER_RESET_InLow) begin
            r_tick_pend <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (SC_MOVEARBITER_laneTick_InHigh)
                r_tick_pend <= 1'b1;
            else if (w_shift_ack)
                r_tick_pend <= 1'b0;
            if (SC_MOVEARBITER_laneTick_InHigh && r_tick_pend && !w_shift_ack)
                r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge SC_MOVEARBITER_CLOCK_50 or negedge SC_MOVEARBITER_RESET_InLow) begin
        if (!SC_MOVEARBITER_RESET_InLow) begin
            r_state <= S_IDLE;
            r_cmd   <= CMD_NOP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cmd   <= w_cmd_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_nxt   = r_cmd;
        w_cnt_nxt   = r_cnt;
        w_arm_clr   = 1'b0;
        w_dir_latch = '0;
        case (r_state)
            S_IDLE: begin
                w_cmd_nxt = CMD_NOP;
                if (r_tick_pend) begin
                    w_cmd_nxt   = CMD_SHIFT;
                    w_state_nxt = S_ISSUE;
                end else if (w_armed_eff && (|w_pressed)) begin
                    w_arm_clr   = 1'b1;
                    w_state_nxt = S_ISSUE;
                    if (w_pressed[0]) begin
                        w_cmd_nxt = CMD_START;
                    end else if (w_pressed[1]) begin
                        w_cmd_nxt   = CMD_UP;
                        w_dir_latch = 5'b00010;
                    end else if (w_pressed[2]) begin
                        if (SC_MOVEARBITER_bottomsidecomparator_InLow) begin
                            w_cmd_nxt   = CMD_DOWN;
                            w_dir_latch = 5'b00100;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else if (w_pressed[3]) begin
                        w_cmd_nxt   = CMD_LEFT;
                        w_dir_latch = 5'b01000;
                    end else begin
                        w_cmd_nxt   = CMD_RIGHT;
                        w_dir_latch = 5'b10000;
                    end
                end
            end
            S_ISSUE: begin
                if (SC_MOVEARBITER_cmdAck_InHigh) begin
                    w_cmd_nxt = CMD_NOP;
                    if (r_cmd == CMD_SHIFT) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                w_cmd_nxt = CMD_NOP;
                if (r_cnt == '0)
                    w_state_nxt = S_IDLE;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cmd_nxt   = CMD_NOP;
            end
        endcase
    end

`ifdef SC_MOVEARBITER_REPEAT_EN
    logic [CW-1:0] r_rpt_cnt;
    logic [4:0]    r_rpt_btn;

    // Repeat fires only while exactly the last accepted direction stays held.
    assign w_rpt_fire = (r_rpt_btn != '0) && (w_pressed == r_rpt_btn) && (r_rpt_cnt == '0);

    always_ff @(posedge SC_MOVEARBITER_CLOCK_50 or negedge SC_MOVEARBITER_RESET_InLow) begin
        if (!SC_MOVEARBITER_RESET_InLow) begin
            r_rpt_cnt <= '0;
            r_rpt_btn <= '0;
        end else if (w_dir_latch != '0) begin
            r_rpt_btn <= w_dir_latch;
            r_rpt_cnt <= CW'(REPEAT_CYCLES - 1);
        end else if (w_pressed != r_rpt_btn) begin
            r_rpt_btn <= '0;
        end else if (r_rpt_cnt != '0) begin
            r_rpt_cnt <= r_rpt_cnt - 1'b1;
        end
    end
`else
    logic w_unused_dir;
    assign w_unused_dir = |w_dir_latch;
    assign w_rpt_fire   = 1'b0;
`endif

    assign SC_MOVEARBITER_cmdValid_OutHigh = (r_state == S_ISSUE);
    assign SC_MOVEARBITER_cmd_Out          = r_cmd;
    assign SC_MOVEARBITER_busy_OutHigh     = (r_state != S_IDLE);
    assign SC_MOVEARBITER_overrun_OutHigh  = r_overrun;

endmodule

// File: tb/tb_sc_move_arbiter.sv
// Directed self-checking bench for sc_move_arbiter (GAP_CYCLES=4, REPEAT_CYCLES=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sc_move_arbiter;

    logic       clk;
    logic       rst_n;
    logic       start_n, up_n, down_n, left_n, right_n;
    logic       bottom_n;
    logic       tick;
    logic       ack;
    logic       valid;
    logic [2:0] cmd;
    logic       busy;
    logic       overrun;

    int unsigned n_tests;
    int unsigned n_fail;

    sc_move_arbiter #(
        .GAP_CYCLES    (4),
        .REPEAT_CYCLES (8)
    ) dut (
        .SC_MOVEARBITER_CLOCK_50                   (clk),
        .SC_MOVEARBITER_RESET_InLow                (rst_n),
        .SC_MOVEARBITER_startButton_InLow          (start_n),
        .SC_MOVEARBITER_upButton_InLow             (up_n),
        .SC_MOVEARBITER_downButton_InLow           (down_n),
        .SC_MOVEARBITER_leftButton_InLow           (left_n),
        .SC_MOVEARBITER_rightButton_InLow          (right_n),
        .SC_MOVEARBITER_bottomsidecomparator_InLow (bottom_n),
        .SC_MOVEARBITER_laneTick_InHigh            (tick),
        .SC_MOVEARBITER_cmdAck_InHigh              (ack),
        .SC_MOVEARBITER_cmdValid_OutHigh           (valid),
        .SC_MOVEARBITER_cmd_Out                    (cmd),
        .SC_MOVEARBITER_busy_OutHigh               (busy),
        .SC_MOVEARBITER_overrun_OutHigh            (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic settle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start_n = 1'b1; up_n = 1'b0; down_n = 1'b1; left_n = 1'b1;
        right_n = 1'b1; bottom_n = 1'b1; tick = 1'b0; ack = 1'b0;
        settle(2);
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset valid got %0b exp 0", valid); end
        n_tests++; if (cmd !== 3'd0) begin n_fail++; $display("FAIL reset cmd got %0d exp 0", cmd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %0b exp 0", busy); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun got %0b exp 0", overrun); end
        rst_n = 1'b1;
        // up held through reset must not fire
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL held_up k=%0d valid got %0b exp 0", k, valid); end
        end
        up_n = 1'b1;
        settle(4);
        up_n = 1'b0;
        for (int unsigned k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++;
            if (valid !== (k == 2)) begin n_fail++; $display("FAIL repress k=%0d valid got %0b exp %0b", k, valid, (k == 2)); end
            n_tests++;
            if (cmd !== ((k == 2) ? 3'd2 : 3'd0)) begin n_fail++; $display("FAIL repress k=%0d cmd got %0d exp %0d", k, cmd, (k == 2) ? 2 : 0); end
            if (k == 2) begin ack = 1'b1; up_n = 1'b1; end
        end
        settle(6);
    endtask

    task automatic test_gap;
        logic exp_busy;
        ack = 1'b1;
        up_n = 1'b0;
        for (int unsigned k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_busy = (k >= 2) && (k <= 6);
            n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL gap k=%0d busy got %0b exp %0b", k, busy, exp_busy); end
            n_tests++; if (valid !== (k == 2)) begin n_fail++; $display("FAIL gap k=%0d valid got %0b exp %0b", k, valid, (k == 2)); end
            n_tests++;
            if (cmd !== ((k == 2) ? 3'd2 : 3'd0)) begin n_fail++; $display("FAIL gap k=%0d cmd got %0d exp %0d", k, cmd, (k == 2) ? 2 : 0); end
            if (k == 3) up_n = 1'b1;
            if (k == 4) up_n = 1'b0;
            if (k == 5) up_n = 1'b1;
        end
        ack = 1'b0;
        settle(4);
    endtask

    task automatic test_tick_left;
        logic [2:0] exp_cmd;
        tick = 1'b1;
        left_n = 1'b0;
        ack = 1'b0;
        for (int unsigned k = 0; k < 11; k++) begin
            @(negedge clk);
            exp_cmd = (k == 1 || k == 2) ? 3'd6 : ((k == 4) ? 3'd4 : 3'd0);
            n_tests++;
            if (valid !== (k == 1 || k == 2 || k == 4)) begin n_fail++; $display("FAIL tick_left k=%0d valid got %0b exp %0b", k, valid, (k == 1 || k == 2 || k == 4)); end
            n_tests++; if (cmd !== exp_cmd) begin n_fail++; $display("FAIL tick_left k=%0d cmd got %0d exp %0d", k, cmd, exp_cmd); end
            if (k == 0) tick = 1'b0;
            if (k == 2) ack = 1'b1;
            if (k == 4) left_n = 1'b1;
        end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL tick_left overrun got %0b exp 0", overrun); end
        ack = 1'b0;
        settle(4);
    endtask

    task automatic test_bottom;
        bottom_n = 1'b0;
        down_n = 1'b0;
        ack = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL bottom_drop k=%0d valid got %0b exp 0", k, valid); end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bottom_drop k=%0d busy got %0b exp 0", k, busy); end
        end
        down_n = 1'b1;
        bottom_n = 1'b1;
        settle(4);
        down_n = 1'b0;
        for (int unsigned k = 0; k < 9; k++) begin
            @(negedge clk);
            n_tests++; if (valid !== (k == 2)) begin n_fail++; $display("FAIL bottom_ok k=%0d valid got %0b exp %0b", k, valid, (k == 2)); end
            n_tests++;
            if (cmd !== ((k == 2) ? 3'd3 : 3'd0)) begin n_fail++; $display("FAIL bottom_ok k=%0d cmd got %0d exp %0d", k, cmd, (k == 2) ? 3 : 0); end
            if (k == 3) down_n = 1'b1;
        end
        ack = 1'b0;
        settle(4);
    endtask

    task automatic test_repeat;
        logic exp_valid;
        int unsigned n_pulses;
        n_pulses = 0;
        ack = 1'b1;
        right_n = 1'b0;
        for (int unsigned k = 0; k < 30; k++) begin
            @(negedge clk);
`ifdef SC_MOVEARBITER_REPEAT_EN
            exp_valid = (k >= 2) && (((k - 2) % 8) == 0);
`else
            exp_valid = (k == 2);
`endif
            if (valid === 1'b1 && cmd === 3'd5) n_pulses++;
            n_tests++; if (valid !== exp_valid) begin n_fail++; $display("FAIL repeat k=%0d valid got %0b exp %0b", k, valid, exp_valid); end
            n_tests++;
            if (cmd !== (exp_valid ? 3'd5 : 3'd0)) begin n_fail++; $display("FAIL repeat k=%0d cmd got %0d exp %0d", k, cmd, exp_valid ? 5 : 0); end
        end
        n_tests++;
`ifdef SC_MOVEARBITER_REPEAT_EN
        if (n_pulses != 4) begin n_fail++; $display("FAIL repeat_count got %0d exp 4", n_pulses); end
`else
        if (n_pulses != 1) begin n_fail++; $display("FAIL repeat_count got %0d exp 1", n_pulses); end
`endif
        right_n = 1'b1;
        settle(8);
        ack = 1'b0;
    endtask

    task automatic test_overrun_reset;
        ack = 1'b0;
        tick = 1'b1;
        for (int unsigned k = 0; k < 20; k++) begin
            @(negedge clk);
            n_tests++; if (valid !== (k >= 1)) begin n_fail++; $display("FAIL overrun k=%0d valid got %0b exp %0b", k, valid, (k >= 1)); end
            n_tests++;
            if (cmd !== ((k >= 1) ? 3'd6 : 3'd0)) begin n_fail++; $display("FAIL overrun k=%0d cmd got %0d exp %0d", k, cmd, (k >= 1) ? 6 : 0); end
            n_tests++; if (overrun !== (k >= 6)) begin n_fail++; $display("FAIL overrun k=%0d overrun got %0b exp %0b", k, overrun, (k >= 6)); end
            tick = (k == 5);
        end
        tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midreset valid got %0b exp 0", valid); end
        n_tests++; if (cmd !== 3'd0) begin n_fail++; $display("FAIL midreset cmd got %0d exp 0", cmd); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy got %0b exp 0", busy); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midreset overrun got %0b exp 0", overrun); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL postreset k=%0d valid got %0b exp 0", k, valid); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset;
        test_gap;
        test_tick_left;
        test_bottom;
        test_repeat;
        test_overrun_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
